// File: rtl/bbpd_alexander_pd.sv
// Alexander bang-bang phase detector for the CDR loop.
// Ports:
//   clk, rst       : sample clock, synchronous active-high reset
//   en             : sample-valid qualifier for the (Dn_1, Pn, Dn) triple
//   cnt_clr        : synchronous clear of both event counters
//   Dn_1, Pn, Dn   : previous data, edge, current data samples
//   decision       : registered 01 early, 10 late, 00 none
//   dec_valid      : decision holds a sampled triple this cycle
//   early_cnt      : saturating count of early decisions
//   late_cnt       : saturating count of late decisions
module bbpd_alexander_pd #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic             Dn_1,
    input  logic             Pn,
    input  logic             Dn,
    output logic [1:0]       decision,
    output logic             dec_valid,
    output logic [CNT_W-1:0] early_cnt,
    output logic [CNT_W-1:0] late_cnt
);

    logic trans;
    logic early;
    logic late;

    // With a data transition the edge sample agrees with exactly one
    // data sample, so early and late can never be asserted together.
    assign trans = Dn_1 ^ Dn;
    assign early = trans & (Pn == Dn_1);
    assign late  = trans & (Pn == Dn);

    always_ff @(posedge clk) begin
        if (rst) begin
            decision  <= 2'b00;
            dec_valid <= 1'b0;
        end else if (en) begin
            decision  <= {late, early};
            dec_valid <= 1'b1;
        end else begin
            decision  <= 2'b00;
            dec_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            early_cnt <= '0;
            late_cnt  <= '0;
        end else if (en) begin
            if (early && (early_cnt != '1))
                early_cnt <= early_cnt + 1'b1;
            if (late && (late_cnt != '1))
                late_cnt <= late_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_bbpd_alexander_pd.sv
// Bench for bbpd_alexander_pd with 2-bit counters so that saturation
// is reachable; expected outputs are queued on drive, checked after the edge.
module tb_bbpd_alexander_pd;

    localparam int W = 2;
    localparam logic [W-1:0] CMAX = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         cnt_clr = 1'b0;
    logic         Dn_1 = 1'b0;
    logic         Pn = 1'b0;
    logic         Dn = 1'b0;
    logic [1:0]   decision;
    logic         dec_valid;
    logic [W-1:0] early_cnt;
    logic [W-1:0] late_cnt;

    bbpd_alexander_pd #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .cnt_clr(cnt_clr),
        .Dn_1(Dn_1), .Pn(Pn), .Dn(Dn),
        .decision(decision), .dec_valid(dec_valid),
        .early_cnt(early_cnt), .late_cnt(late_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       clr;
        logic [2:0] dpd;
        logic [1:0] dec;
        logic       vld;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] dec;
        logic       vld;
        logic [W-1:0] e;
        logic [W-1:0] l;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] m_e = '0;
    logic [W-1:0] m_l = '0;

    // Reference rule written from the truth table of the phase decision.
    function automatic logic [1:0] ref_dec(input logic [2:0] t);
        case (t)
            3'b001, 3'b110: ref_dec = 2'b01;
            3'b011, 3'b100: ref_dec = 2'b10;
            default:        ref_dec = 2'b00;
        endcase
    endfunction

    task automatic apply(input string nm, input logic r, input logic e,
                         input logic c, input logic [2:0] t,
                         input logic [1:0] xd, input logic xv);
        exp_t x;
        exp_t got;
        rst = r;
        en = e;
        cnt_clr = c;
        {Dn_1, Pn, Dn} = t;
        if (r || c) begin
            m_e = '0;
            m_l = '0;
        end else if (e) begin
            if (xd == 2'b01 && m_e != CMAX) m_e = m_e + 1'b1;
            if (xd == 2'b10 && m_l != CMAX) m_l = m_l + 1'b1;
        end
        x.name = nm;
        x.dec = xd;
        x.vld = xv;
        x.e = m_e;
        x.l = m_l;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_vec++;
        if (decision !== got.dec || dec_valid !== got.vld ||
            early_cnt !== got.e || late_cnt !== got.l) begin
            n_bad++;
            $display("FAIL %s: got dec=%b vld=%b e=%0d l=%0d, want dec=%b vld=%b e=%0d l=%0d",
                     got.name, decision, dec_valid, early_cnt, late_cnt,
                     got.dec, got.vld, got.e, got.l);
        end
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 3'b001, 2'b00, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 3'b001, 2'b01, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 3'b110, 2'b01, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 3'b011, 2'b10, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 3'b100, 2'b10, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 3'b010, 2'b00, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 3'b101, 2'b00, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 3'b111, 2'b00, 1'b1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 1'b0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 3'b100, 2'b00, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 3'b011, 2'b10, 1'b1};
        vt[13] = '{1'b0, 1'b1, 1'b0, 3'b100, 2'b10, 1'b1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), vt[i].rst, vt[i].en,
                  vt[i].clr, vt[i].dpd, vt[i].dec, vt[i].vld);

        apply("clr_idle", 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++)
            apply($sformatf("sat_e%0d", i), 1'b0, 1'b1, 1'b0,
                  3'b001, 2'b01, 1'b1);
        apply("clr_wins", 1'b0, 1'b1, 1'b1, 3'b110, 2'b01, 1'b1);
        apply("post_clr", 1'b0, 1'b1, 1'b0, 3'b110, 2'b01, 1'b1);
        apply("late_a", 1'b0, 1'b1, 1'b0, 3'b011, 2'b10, 1'b1);
        apply("late_b", 1'b0, 1'b1, 1'b0, 3'b100, 2'b10, 1'b1);
        apply("mid_rst", 1'b1, 1'b1, 1'b0, 3'b011, 2'b00, 1'b0);
        apply("after_rst", 1'b0, 1'b1, 1'b0, 3'b001, 2'b01, 1'b1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] t;
            logic       e;
            logic       c;
            t = 3'($urandom_range(0, 7));
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            apply($sformatf("rnd%0d", i), 1'b0, e, c, t,
                  e ? ref_dec(t) : 2'b00, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
